// File: rtl/pipe_pkg.sv
// Shared definitions for the 8-bit pipeline: datapath widths, ALU opcode
// encoding and the multiply sequencer state type.
package pipe_pkg;

   localparam int DATA_W    = 8;
   localparam int REG_NUM_W = 3;

   // ALU opcode as carried in the ID/EX ALUOp field
   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_AND   = 2'b10,
      ALU_PASSB = 2'b11
   } alu_op_t;

   // Multiply sequencer states (only instantiated when MUL_EN is defined)
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } mul_state_t;

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU for the execute stage. Carry is the ADD carry-out or the
// SUB borrow; for AND/PASSB it is driven 0 and the caller holds its flag.
module ex_alu #(
   parameter int DATA_W = pipe_pkg::DATA_W
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  pipe_pkg::alu_op_t alu_op,
   output logic [DATA_W-1:0] result,
   output logic              carry
);
   import pipe_pkg::*;

   logic [DATA_W:0] sum;

   assign sum = {1'b0, a} + {1'b0, b};

   // Opcode decode; borrow is the unsigned a<b comparison
   always_comb begin
      result = '0;
      carry  = 1'b0;
      case (alu_op)
         ALU_ADD: begin
            result = sum[DATA_W-1:0];
            carry  = sum[DATA_W];
         end
         ALU_SUB: begin
            result = a - b;
            carry  = (a < b);
         end
         ALU_AND:   result = a & b;
         ALU_PASSB: result = b;
         default: begin
            result = '0;
            carry  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/ex_wb_stage.sv
// Execute stage plus EX/WB pipeline register. Forwards the EX/WB result to
// either source operand, runs the ALU and keeps the Zero/Carry flags.
// Optional 2-cycle multiply sequencer enabled by defining MUL_EN.
// Handshake: Stall_Out is combinational; while it is 1 the upstream stage must
// hold ID/EX unchanged, and this stage re-reads the same instruction next cycle.
module ex_wb_stage #(
   parameter int DATA_W    = pipe_pkg::DATA_W,
   parameter int REG_NUM_W = pipe_pkg::REG_NUM_W
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 ID_EX_Valid,
   input  logic                 ID_EX_RegWrite,
   input  logic                 ID_EX_ALUSrc,
   input  logic [1:0]           ID_EX_ALUOp,
   input  logic                 ID_EX_Mul,
   input  logic [DATA_W-1:0]    ID_EX_Read_Data1,
   input  logic [DATA_W-1:0]    ID_EX_Read_Data2,
   input  logic [REG_NUM_W-1:0] ID_EX_Read_Reg_Num1,
   input  logic [REG_NUM_W-1:0] ID_EX_Read_Reg_Num2,
   input  logic [DATA_W-1:0]    ID_EX_Imm_Data,
   input  logic [REG_NUM_W-1:0] ID_EX_Write_Reg_Num,
   output logic                 EX_WB_Valid,
   output logic                 EX_WB_RegWrite,
   output logic [REG_NUM_W-1:0] EX_WB_Write_Reg_Num,
   output logic [DATA_W-1:0]    EX_WB_Result,
   output logic                 Zero_Flag,
   output logic                 Carry_Flag,
   output logic                 Stall_Out
);
   import pipe_pkg::*;

   logic                 fwd_a_hit;
   logic                 fwd_b_hit;
   logic [DATA_W-1:0]    op_a;
   logic [DATA_W-1:0]    op_b;
   alu_op_t              alu_op;
   logic [DATA_W-1:0]    alu_result;
   logic                 alu_carry;

   // Next-state of the EX/WB register and flags
   logic                 wb_load;
   logic                 wb_valid_d;
   logic                 wb_rw_d;
   logic [DATA_W-1:0]    wb_result_d;
   logic [REG_NUM_W-1:0] wb_dest_d;
   logic                 zero_upd;
   logic                 carry_upd;
   logic                 carry_d;
   logic                 stall;

   // Forwarding only from a real, register-writing EX/WB entry (R0 included)
   assign fwd_a_hit = EX_WB_Valid && EX_WB_RegWrite &&
                      (EX_WB_Write_Reg_Num == ID_EX_Read_Reg_Num1);
   assign fwd_b_hit = EX_WB_Valid && EX_WB_RegWrite &&
                      (EX_WB_Write_Reg_Num == ID_EX_Read_Reg_Num2);
   assign op_a      = fwd_a_hit ? EX_WB_Result : ID_EX_Read_Data1;
   assign op_b      = ID_EX_ALUSrc ? ID_EX_Imm_Data :
                      (fwd_b_hit ? EX_WB_Result : ID_EX_Read_Data2);
   assign alu_op    = alu_op_t'(ID_EX_ALUOp);

   ex_alu #(.DATA_W(DATA_W)) u_alu (
      .a      (op_a),
      .b      (op_b),
      .alu_op (alu_op),
      .result (alu_result),
      .carry  (alu_carry)
   );

`ifdef MUL_EN
   mul_state_t              state;
   mul_state_t              next_state;
   logic                    capture;
   logic [DATA_W-1:0]       cap_a;
   logic [DATA_W-1:0]       cap_b;
   logic [REG_NUM_W-1:0]    cap_dest;
   logic                    cap_rw;
   logic [2*DATA_W-1:0]     product;

   assign product = {{DATA_W{1'b0}}, cap_a} * {{DATA_W{1'b0}}, cap_b};

   // Sequencer state register; reset aborts any multiply in flight
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) state <= ST_IDLE;
      else        state <= next_state;
   end

   // Operand/destination capture at the start of a multiply
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         cap_a    <= '0;
         cap_b    <= '0;
         cap_dest <= '0;
         cap_rw   <= 1'b0;
      end else if (capture) begin
         cap_a    <= op_a;
         cap_b    <= op_b;
         cap_dest <= ID_EX_Write_Reg_Num;
         cap_rw   <= ID_EX_RegWrite;
      end
   end
`endif

   // Next-state logic for the EX/WB register, flags, stall and sequencer
   always_comb begin
      wb_load     = 1'b0;
      wb_valid_d  = 1'b0;
      wb_rw_d     = 1'b0;
      wb_result_d = alu_result;
      wb_dest_d   = ID_EX_Write_Reg_Num;
      zero_upd    = 1'b0;
      carry_upd   = 1'b0;
      carry_d     = alu_carry;
      stall       = 1'b0;
`ifdef MUL_EN
      next_state  = state;
      capture     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (ID_EX_Valid && ID_EX_Mul) begin
               // Hold upstream one cycle and put a bubble into EX/WB
               stall      = 1'b1;
               capture    = 1'b1;
               next_state = ST_MUL;
            end else if (ID_EX_Valid) begin
               wb_load    = 1'b1;
               wb_valid_d = 1'b1;
               wb_rw_d    = ID_EX_RegWrite;
               zero_upd   = 1'b1;
               carry_upd  = (alu_op == ALU_ADD) || (alu_op == ALU_SUB);
            end
         end
         ST_MUL: begin
            // ID/EX is ignored here; the captured operands finish the multiply
            wb_load     = 1'b1;
            wb_valid_d  = 1'b1;
            wb_rw_d     = cap_rw;
            wb_result_d = product[DATA_W-1:0];
            wb_dest_d   = cap_dest;
            zero_upd    = 1'b1;
            carry_upd   = 1'b1;
            carry_d     = |product[2*DATA_W-1:DATA_W];
            next_state  = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
`else
      if (ID_EX_Valid) begin
         wb_load    = 1'b1;
         wb_valid_d = 1'b1;
         wb_rw_d    = ID_EX_RegWrite;
         zero_upd   = 1'b1;
         carry_upd  = (alu_op == ALU_ADD) || (alu_op == ALU_SUB);
      end
`endif
   end

   assign Stall_Out = stall;

   // EX/WB register and flags; bubbles clear Valid/RegWrite and hold the rest
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         EX_WB_Valid         <= 1'b0;
         EX_WB_RegWrite      <= 1'b0;
         EX_WB_Write_Reg_Num <= '0;
         EX_WB_Result        <= '0;
         Zero_Flag           <= 1'b0;
         Carry_Flag          <= 1'b0;
      end else begin
         EX_WB_Valid    <= wb_valid_d;
         EX_WB_RegWrite <= wb_valid_d && wb_rw_d;
         if (wb_load) begin
            EX_WB_Result        <= wb_result_d;
            EX_WB_Write_Reg_Num <= wb_dest_d;
         end
         if (zero_upd)  Zero_Flag  <= (wb_result_d == '0);
         if (carry_upd) Carry_Flag <= carry_d;
      end
   end

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed bench for ex_wb_stage: a table of ALU/forwarding/bubble vectors
// followed by hand-written reset and (with MUL_EN) multiply sequences.
module tb_ex_wb_stage;
   import pipe_pkg::*;

   logic       Clk;
   logic       Reset;
   logic       ID_EX_Valid;
   logic       ID_EX_RegWrite;
   logic       ID_EX_ALUSrc;
   logic [1:0] ID_EX_ALUOp;
   logic       ID_EX_Mul;
   logic [7:0] ID_EX_Read_Data1;
   logic [7:0] ID_EX_Read_Data2;
   logic [2:0] ID_EX_Read_Reg_Num1;
   logic [2:0] ID_EX_Read_Reg_Num2;
   logic [7:0] ID_EX_Imm_Data;
   logic [2:0] ID_EX_Write_Reg_Num;
   logic       EX_WB_Valid;
   logic       EX_WB_RegWrite;
   logic [2:0] EX_WB_Write_Reg_Num;
   logic [7:0] EX_WB_Result;
   logic       Zero_Flag;
   logic       Carry_Flag;
   logic       Stall_Out;

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q[$];

   ex_wb_stage dut (
      .Clk                 (Clk),
      .Reset               (Reset),
      .ID_EX_Valid         (ID_EX_Valid),
      .ID_EX_RegWrite      (ID_EX_RegWrite),
      .ID_EX_ALUSrc        (ID_EX_ALUSrc),
      .ID_EX_ALUOp         (ID_EX_ALUOp),
      .ID_EX_Mul           (ID_EX_Mul),
      .ID_EX_Read_Data1    (ID_EX_Read_Data1),
      .ID_EX_Read_Data2    (ID_EX_Read_Data2),
      .ID_EX_Read_Reg_Num1 (ID_EX_Read_Reg_Num1),
      .ID_EX_Read_Reg_Num2 (ID_EX_Read_Reg_Num2),
      .ID_EX_Imm_Data      (ID_EX_Imm_Data),
      .ID_EX_Write_Reg_Num (ID_EX_Write_Reg_Num),
      .EX_WB_Valid         (EX_WB_Valid),
      .EX_WB_RegWrite      (EX_WB_RegWrite),
      .EX_WB_Write_Reg_Num (EX_WB_Write_Reg_Num),
      .EX_WB_Result        (EX_WB_Result),
      .Zero_Flag           (Zero_Flag),
      .Carry_Flag          (Carry_Flag),
      .Stall_Out           (Stall_Out)
   );

   // ---------------- clock / reset ----------------
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic       valid, rw, alusrc;
      logic [1:0] op;
      logic [2:0] rn1;
      logic [7:0] rd1;
      logic [2:0] rn2;
      logic [7:0] rd2;
      logic [7:0] imm;
      logic [2:0] wn;
      logic       e_valid, e_rw;
      logic [2:0] e_wn;
      logic [7:0] e_res;
      logic       e_zero, e_carry;
   } vec_t;

   vec_t vecs[13];

   function automatic vec_t mk(input logic valid, rw, alusrc, input logic [1:0] op,
                               input logic [2:0] rn1, input logic [7:0] rd1,
                               input logic [2:0] rn2, input logic [7:0] rd2,
                               input logic [7:0] imm, input logic [2:0] wn,
                               input logic e_valid, e_rw, input logic [2:0] e_wn,
                               input logic [7:0] e_res, input logic e_zero, e_carry);
      vec_t v;
      v.valid = valid; v.rw = rw; v.alusrc = alusrc; v.op = op;
      v.rn1 = rn1; v.rd1 = rd1; v.rn2 = rn2; v.rd2 = rd2; v.imm = imm; v.wn = wn;
      v.e_valid = e_valid; v.e_rw = e_rw; v.e_wn = e_wn; v.e_res = e_res;
      v.e_zero = e_zero; v.e_carry = e_carry;
      return v;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input vec_t v, input logic mul);
      ID_EX_Valid         = v.valid;
      ID_EX_RegWrite      = v.rw;
      ID_EX_ALUSrc        = v.alusrc;
      ID_EX_ALUOp         = v.op;
      ID_EX_Mul           = mul;
      ID_EX_Read_Reg_Num1 = v.rn1;
      ID_EX_Read_Data1    = v.rd1;
      ID_EX_Read_Reg_Num2 = v.rn2;
      ID_EX_Read_Data2    = v.rd2;
      ID_EX_Imm_Data      = v.imm;
      ID_EX_Write_Reg_Num = v.wn;
   endtask

   task automatic idle_inputs();
      vec_t v;
      v = mk(0,0,0,2'b00, 0,8'h00, 0,8'h00, 8'h00, 0, 0,0,0,8'h00,0,0);
      drive(v, 1'b0);
   endtask

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_outputs(input string tag, input logic v, rw, input logic [2:0] wn,
                              input logic z, c);
      logic [7:0] exp_res;
      exp_res = exp_q.pop_front();
      chk({tag, ".valid"},  32'(EX_WB_Valid),         32'(v));
      chk({tag, ".rw"},     32'(EX_WB_RegWrite),      32'(rw));
      chk({tag, ".wn"},     32'(EX_WB_Write_Reg_Num), 32'(wn));
      chk({tag, ".result"}, 32'(EX_WB_Result),        32'(exp_res));
      chk({tag, ".zero"},   32'(Zero_Flag),           32'(z));
      chk({tag, ".carry"},  32'(Carry_Flag),          32'(c));
   endtask

   task automatic chk_all_zero(input string tag);
      exp_q.push_back(8'h00);
      chk_outputs(tag, 0, 0, 3'd0, 0, 0);
      chk({tag, ".stall"}, 32'(Stall_Out), 32'd0);
   endtask

   // ---------------- test ----------------
   initial begin
      vec_t v;
      vecs[0]  = mk(1,1,0,ALU_ADD,   1,8'hF0, 2,8'h20, 8'h00, 3, 1,1,3,8'h10,0,1);
      vecs[1]  = mk(1,1,1,ALU_SUB,   3,8'h55, 0,8'h00, 8'h10, 4, 1,1,4,8'h00,1,0);
      vecs[2]  = mk(0,1,0,ALU_ADD,   7,8'hAA, 7,8'hAA, 8'h00, 7, 0,0,4,8'h00,1,0);
      vecs[3]  = mk(1,1,0,ALU_ADD,   4,8'h33, 5,8'h01, 8'h00, 6, 1,1,6,8'h34,0,0);
      vecs[4]  = mk(1,1,0,ALU_ADD,   0,8'hFF, 1,8'h01, 8'h00, 1, 1,1,1,8'h00,1,1);
      vecs[5]  = mk(1,1,1,ALU_PASSB, 0,8'h00, 0,8'h00, 8'h7E, 2, 1,1,2,8'h7E,0,1);
      vecs[6]  = mk(1,1,0,ALU_AND,   2,8'h00, 0,8'h0F, 8'h00, 0, 1,1,0,8'h0E,0,1);
      vecs[7]  = mk(1,0,1,ALU_SUB,   0,8'h99, 0,8'h00, 8'h20, 5, 1,0,5,8'hEE,0,1);
      vecs[8]  = mk(1,1,0,ALU_ADD,   5,8'h01, 5,8'h02, 8'h00, 7, 1,1,7,8'h03,0,0);
      vecs[9]  = mk(1,1,1,ALU_PASSB, 7,8'h00, 7,8'h00, 8'h05, 0, 1,1,0,8'h05,0,0);
      vecs[10] = mk(1,1,0,ALU_SUB,   1,8'h03, 0,8'h40, 8'h00, 1, 1,1,1,8'hFE,0,1);
      vecs[11] = mk(1,1,1,ALU_ADD,   1,8'h00, 0,8'h00, 8'h02, 3, 1,1,3,8'h00,1,1);
      vecs[12] = mk(0,0,0,ALU_SUB,   3,8'h00, 3,8'h00, 8'h00, 2, 0,0,3,8'h00,1,1);

      Reset = 1'b0;
      idle_inputs();
      #3;
      chk_all_zero("reset0");
      @(negedge Clk);
      Reset = 1'b1;

      // Table: drive at negedge, check stall immediately, check outputs next negedge
      for (int i = 0; i < 13; i++) begin
         drive(vecs[i], 1'b0);
         exp_q.push_back(vecs[i].e_res);
         #1;
         chk($sformatf("v%0d.stall", i), 32'(Stall_Out), 32'd0);
         @(negedge Clk);
         chk_outputs($sformatf("v%0d", i), vecs[i].e_valid, vecs[i].e_rw,
                     vecs[i].e_wn, vecs[i].e_zero, vecs[i].e_carry);
      end

`ifndef MUL_EN
      // Mul request must be ignored: executes as SUB 0x10-0x30
      v = mk(1,1,1,ALU_SUB, 6,8'h10, 0,8'h00, 8'h30, 4, 1,1,4,8'hE0,0,1);
      drive(v, 1'b1);
      exp_q.push_back(8'hE0);
      #1;
      chk("mulign.stall", 32'(Stall_Out), 32'd0);
      @(negedge Clk);
      chk_outputs("mulign", 1, 1, 3'd4, 0, 1);
`endif

      // Reset mid-run with non-zero state, no clock edge involved
      v = mk(1,1,0,ALU_ADD, 1,8'hF0, 2,8'h20, 8'h00, 3, 0,0,0,8'h00,0,0);
      drive(v, 1'b0);
      @(negedge Clk);
      exp_q.push_back(8'h10);
      chk_outputs("pre_rst", 1, 1, 3'd3, 0, 1);
      #2;
      Reset = 1'b0;
      #1;
      chk_all_zero("rst_mid");
      idle_inputs();
      @(negedge Clk);
      Reset = 1'b1;

`ifdef MUL_EN
      // 0x12 * 0x10 into R5: one stall cycle, one bubble, then 0x20 with carry
      v = mk(1,1,0,ALU_ADD, 1,8'h12, 2,8'h10, 8'h00, 5, 0,0,0,8'h00,0,0);
      drive(v, 1'b1);
      #1;
      chk("mul.stall1", 32'(Stall_Out), 32'd1);
      @(negedge Clk);
      chk("mul.bubble_valid", 32'(EX_WB_Valid), 32'd0);
      chk("mul.bubble_rw", 32'(EX_WB_RegWrite), 32'd0);
      chk("mul.stall2", 32'(Stall_Out), 32'd0);
      @(negedge Clk);
      exp_q.push_back(8'h20);
      chk_outputs("mul.res", 1, 1, 3'd5, 0, 1);
      // Following instruction forwards R5
      v = mk(1,1,1,ALU_ADD, 5,8'h00, 0,8'h00, 8'h01, 6, 0,0,0,8'h00,0,0);
      drive(v, 1'b0);
      #1;
      chk("mul.next_stall", 32'(Stall_Out), 32'd0);
      @(negedge Clk);
      exp_q.push_back(8'h21);
      chk_outputs("mul.fwd", 1, 1, 3'd6, 0, 0);

      // Reset inside a multiply: abort, no result afterwards
      v = mk(1,1,0,ALU_ADD, 1,8'h03, 2,8'h03, 8'h00, 2, 0,0,0,8'h00,0,0);
      drive(v, 1'b1);
      @(negedge Clk);
      #2;
      Reset = 1'b0;
      #1;
      chk_all_zero("mul.rst");
      idle_inputs();
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      chk("mul.abort_valid", 32'(EX_WB_Valid), 32'd0);
      chk("mul.abort_res", 32'(EX_WB_Result), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ex_wb_stage.md
Name: ex_wb_stage

Overview:
- Execute stage of the 8-bit pipelined processor. It sits directly downstream of the ID/EX pipeline register and consumes its control bits, register read data, immediate and destination register number.
- Selects operands with EX/WB-to-EX forwarding, performs the ALU operation, and registers the result into the EX/WB pipeline register.
- The EX/WB register drives the register-file write port.
- Maintains Zero and Carry flags.

Parameters:
- DATA_W, 8, datapath width.
- REG_NUM_W, 3, register-number width (8 registers).

Ports:
- Clk  in  1  single clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset (asserted when 0).
- ID_EX_Valid  in  1  ID/EX holds a real instruction; 0 = bubble.
- ID_EX_RegWrite  in  1  instruction writes the register file.
- ID_EX_ALUSrc  in  1  1 = operand B is the immediate; 0 = operand B is register 2.
- ID_EX_ALUOp  in  2  00 ADD, 01 SUB, 10 AND, 11 PASSB.
- ID_EX_Mul  in  1  multiply request; ignored unless MUL_EN is defined.
- ID_EX_Read_Data1  in  DATA_W  register-file value for source 1.
- ID_EX_Read_Data2  in  DATA_W  register-file value for source 2.
- ID_EX_Read_Reg_Num1  in  REG_NUM_W  source 1 register number.
- ID_EX_Read_Reg_Num2  in  REG_NUM_W  source 2 register number.
- ID_EX_Imm_Data  in  DATA_W  immediate.
- ID_EX_Write_Reg_Num  in  REG_NUM_W  destination register.
- EX_WB_Valid  out  1  registered valid.
- EX_WB_RegWrite  out  1  register-file write enable; always Valid AND RegWrite.
- EX_WB_Write_Reg_Num  out  REG_NUM_W  register-file write address.
- EX_WB_Result  out  DATA_W  register-file write data.
- Zero_Flag  out  1  registered; last valid result == 0.
- Carry_Flag  out  1  registered; see Behaviour.
- Stall_Out  out  1  combinational; upstream must hold ID/EX this cycle.

Behaviour:
- Reset (Reset=0, asynchronous): all outputs and flags clear to 0; the FSM returns to IDLE. Reset asserted during a multiply aborts it, and no result is produced.
- Latency: one cycle, ID/EX inputs to EX/WB outputs, for ALU operations.
- Forwarding applies to each source independently:
  - If EX_WB_Valid AND EX_WB_RegWrite AND EX_WB_Write_Reg_Num equals the source number, use EX_WB_Result.
  - Otherwise use Read_Data.
  - Applies to every register number, register 0 included.
  - Operand B forwarding only matters when ALUSrc=0; when ALUSrc=1 the immediate always wins.
- Arithmetic, modulo 2^DATA_W:
  - ADD: Carry = bit DATA_W of A+B.
  - SUB: Result = A-B; Carry = borrow, i.e. (A<B) unsigned.
  - AND, PASSB: Carry is held.
- Zero updates on every valid instruction.
- Bubble (Valid=0):
  - EX_WB_Valid and EX_WB_RegWrite go to 0.
  - Result and Write_Reg_Num hold their values.
  - Flags hold.
- Valid with RegWrite=0: flags still update; EX_WB_RegWrite goes to 0.

Optional Feature:
- Macro: MUL_EN.
- Defined: 2-cycle multiply, FSM states IDLE and MUL.
  - IDLE with ID_EX_Valid AND ID_EX_Mul:
    - Stall_Out=1 combinationally.
    - Forwarded operands are captured.
    - EX/WB takes a bubble at the edge.
    - FSM goes to MUL.
  - MUL:
    - Stall_Out=0.
    - ID/EX inputs are ignored; the same instruction is still presented.
    - At the edge, EX/WB loads product[DATA_W-1:0] with the captured destination and RegWrite; Valid=1.
    - Zero updates; Carry = OR of product upper bits.
    - FSM goes to IDLE.
  - Two multiplies back to back: the second one re-enters MUL after one IDLE cycle.
- Undefined:
  - ID_EX_Mul is ignored, and the instruction executes per ALUOp.
  - Stall_Out is tied to 0.
  - No FSM is present.

Decomposition:
- Shared package pipe_pkg holds:
  - DATA_W and REG_NUM_W constants.
  - The ALUOp enumeration (ADD, SUB, AND, PASSB).
  - The mul FSM state typedef.
- One combinational sub-module, ex_alu: inputs A, B, ALUOp; outputs Result and Carry.
- Forwarding muxes, flags, FSM and the EX/WB register stay in ex_wb_stage.

Test Plan:
- Reset: drive Reset=0 mid-run, including inside a multiply when MUL_EN is defined → all outputs 0 immediately with no clock edge; FSM in IDLE.
- ADD with carry: R1=0xF0, R2=0x20, ALUOp=00, ALUSrc=0, dest 3 → next cycle Result=0x10, Carry=1, Zero=0, RegWrite=1, Write_Reg_Num=3.
- Forwarding: ADD into R3 giving 0x10, then SUB with Reg_Num1=3 (stale Read_Data1=0x55) and ALUSrc=1, Imm=0x10 → Result=0x00, Zero=1, Carry=0.
- Bubble: Valid=0 between two ops → EX_WB_Valid=0, RegWrite=0, Result held, flags held; no forwarding from the bubble.
- PASSB immediate: ALUSrc=1, Imm=0x7E, ALUOp=11 → Result=0x7E, Carry unchanged.
- MUL_EN: 0x12*0x10 into R5 → Stall_Out=1 for exactly one cycle, one bubble, then Result=0x20, Carry=1; the following instruction's forwarding from R5 sees 0x20.
